// File: rtl/fifo_write_pkg.sv
// Definitions shared by the FIFO loopback traffic generators (write and read controllers).
package fifo_write_pkg;

    localparam int FIFO_DATA_W = 8;
    localparam int BURST_CNT_W = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    // Bits needed for a counter that must reach cycles-1 (never narrower than one bit).
    function automatic int delay_cnt_w(input int cycles);
        if (cycles > 1) begin
            return $clog2(cycles);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/fifo_write.sv
// Write-side traffic generator: waits for a nearly drained FIFO, settles, then bursts an
// incrementing byte pattern until the FIFO is nearly full.
module fifo_write
    import fifo_write_pkg::*;
#(
    parameter int                DATA_W    = FIFO_DATA_W,
    parameter int                DELAY_CYC = 10,
    parameter logic [DATA_W-1:0] DATA_INIT = '0
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   wr_rst_busy,
    input  logic                   almost_empty,
    input  logic                   almost_full,
    input  logic                   full,
    output logic                   fifo_wr_en,
    output logic [DATA_W-1:0]      fifo_wdata,
    output logic                   burst_done,
    output logic [BURST_CNT_W-1:0] burst_cnt
);

    localparam int               CNT_W    = delay_cnt_w(DELAY_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_CYC - 1);

    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       dly_q, dly_d;
    logic                   wr_en_q, wr_en_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic                   done_q, done_d;
    logic [BURST_CNT_W-1:0] bcnt_q, bcnt_d;
    logic                   trig_s;
    logic                   stop_s;
    logic                   burst_end_s;

    assign trig_s = almost_empty && !wr_rst_busy;
    // The stop is registered: the write already on the bus completes into the reserved slot.
    assign stop_s = almost_full || full || wr_rst_busy;

    // FSM next state, settle counter and write enable.
    always_comb begin
        state_d     = state_q;
        dly_d       = dly_q;
        wr_en_d     = wr_en_q;
        burst_end_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wr_en_d = 1'b0;
                dly_d   = '0;
                if (trig_s) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                wr_en_d = 1'b0;
                if (wr_rst_busy) begin
                    state_d = ST_IDLE;
                    dly_d   = '0;
                end else if (dly_q == CNT_LAST) begin
                    state_d = ST_WRITE;
                    wr_en_d = 1'b1;
                    dly_d   = '0;
                end else begin
                    dly_d = dly_q + CNT_W'(1);
                end
            end
            ST_WRITE: begin
                if (stop_s) begin
                    state_d     = ST_IDLE;
                    wr_en_d     = 1'b0;
                    burst_end_s = 1'b1;
                end else begin
                    wr_en_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                wr_en_d = 1'b0;
                dly_d   = '0;
            end
        endcase
    end

    // Pattern advances once per presented write and survives across bursts.
    always_comb begin
        if (wr_en_q) begin
            wdata_d = wdata_q + DATA_W'(1);
        end else begin
            wdata_d = wdata_q;
        end
    end

    // Burst completion pulse and wrapping burst counter.
    always_comb begin
        done_d = burst_end_s;
        if (burst_end_s) begin
            bcnt_d = bcnt_q + BURST_CNT_W'(1);
        end else begin
            bcnt_d = bcnt_q;
        end
    end

    // State and output registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            dly_q   <= '0;
            wr_en_q <= 1'b0;
            wdata_q <= DATA_INIT;
            done_q  <= 1'b0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            wr_en_q <= wr_en_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign fifo_wr_en = wr_en_q;
    assign fifo_wdata = wdata_q;
    assign burst_done = done_q;
    assign burst_cnt  = bcnt_q;

endmodule

// File: tb/tb_fifo_write.sv
// Randomized bench for fifo_write: a depth-16 FIFO model drives the flags, a burst-level
// reference model predicts writes and burst completions, and a monitor scores them.
module tb_fifo_write;

    localparam int DELAY_CYC = 10;
    localparam int DATA_INIT = 0;
    localparam int N_CYC     = 2500;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        wr_rst_busy;
    logic        almost_empty;
    logic        almost_full;
    logic        full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wdata;
    logic        burst_done;
    logic [15:0] burst_cnt;

    typedef struct {
        int e;
        int v;
    } ev_t;

    ev_t wr_q[$];
    ev_t done_q[$];

    int n_checks = 0;
    int n_err    = 0;
    int edge_no  = 0;
    int wr_seen  = 0;
    bit model_live = 1'b0;

    bit m_writing = 1'b0;
    int m_settle  = 0;
    int m_written = 0;
    int m_bursts  = 0;

    fifo_write #(
        .DATA_W   (8),
        .DELAY_CYC(DELAY_CYC),
        .DATA_INIT(8'(DATA_INIT))
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .wr_rst_busy (wr_rst_busy),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .full        (full),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_wdata  (fifo_wdata),
        .burst_done  (burst_done),
        .burst_cnt   (burst_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) edge_no <= edge_no + 1;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    task automatic push_write();
        ev_t ev;
        ev.e = edge_no + 1;
        ev.v = (DATA_INIT + m_written) % 256;
        wr_q.push_back(ev);
        m_written++;
    endtask

    // Burst-level reference: predicts the DUT's reaction to the inputs about to be sampled.
    task automatic model_step();
        ev_t ev;
        if (m_writing) begin
            if (almost_full || full || wr_rst_busy) begin
                m_writing = 1'b0;
                m_bursts++;
                ev.e = edge_no + 1;
                ev.v = m_bursts % 65536;
                done_q.push_back(ev);
            end else begin
                push_write();
            end
        end else if (m_settle > 0) begin
            if (wr_rst_busy) begin
                m_settle = 0;
            end else begin
                m_settle--;
                if (m_settle == 0) begin
                    m_writing = 1'b1;
                    push_write();
                end
            end
        end else if (almost_empty && !wr_rst_busy) begin
            m_settle = DELAY_CYC;
        end
    endtask

    // Monitor: scores every presented write and burst_done pulse against the queues.
    initial begin
        ev_t ev;
        bit  missing;
        forever begin
            @(posedge sys_clk);
            #1;
            if (model_live && !sys_rst) begin
                if (fifo_wr_en) begin
                    if (wr_q.size() == 0) begin
                        check(1'b0, "unexpected_write(edge:data)", edge_no * 256 + int'(fifo_wdata), 0);
                    end else begin
                        ev = wr_q.pop_front();
                        check(ev.e == edge_no && ev.v == int'(fifo_wdata), "write(edge:data)",
                              edge_no * 256 + int'(fifo_wdata), ev.e * 256 + ev.v);
                        wr_seen++;
                    end
                end
                missing = (wr_q.size() > 0) && (wr_q[0].e <= edge_no);
                check(!missing, "missed_write", edge_no, missing ? wr_q[0].e : edge_no);
                if (missing) void'(wr_q.pop_front());

                if (burst_done) begin
                    if (done_q.size() == 0) begin
                        check(1'b0, "unexpected_burst_done", edge_no, 0);
                    end else begin
                        ev = done_q.pop_front();
                        check(ev.e == edge_no && ev.v == int'(burst_cnt), "burst_done(edge:cnt)",
                              edge_no * 65536 + int'(burst_cnt), ev.e * 65536 + ev.v);
                    end
                end
                missing = (done_q.size() > 0) && (done_q[0].e <= edge_no);
                check(!missing, "missed_burst_done", edge_no, missing ? done_q[0].e : edge_no);
                if (missing) void'(done_q.pop_front());

                check(int'(burst_cnt) == m_bursts % 65536, "burst_cnt", int'(burst_cnt), m_bursts % 65536);
            end
        end
    end

    // Stimulus: FIFO model, wr_rst_busy schedule, reset and simultaneous-flag injections.
    initial begin
        int fifo_cnt  = 0;
        int busy_left = 0;
        bit pend_wr   = 1'b0;
        bit pend_rd   = 1'b0;
        bit drain;
        bit rd;
        bit did_rst   = 1'b0;
        bit did_wp    = 1'b0;
        bit did_wrp   = 1'b0;
        bit did_t6    = 1'b0;

        sys_rst      = 1'b1;
        wr_rst_busy  = 1'b1;
        almost_empty = 1'b1;
        almost_full  = 1'b0;
        full         = 1'b0;
        repeat (3) @(negedge sys_clk);
        check(fifo_wr_en == 1'b0, "reset_wr_en", int'(fifo_wr_en), 0);
        check(int'(fifo_wdata) == DATA_INIT, "reset_wdata", int'(fifo_wdata), DATA_INIT);
        check(burst_done == 1'b0, "reset_burst_done", int'(burst_done), 0);
        check(burst_cnt == 16'h0000, "reset_burst_cnt", int'(burst_cnt), 0);

        sys_rst    = 1'b0;
        model_live = 1'b1;
        busy_left  = 20;

        for (int c = 0; c < N_CYC; c++) begin
            fifo_cnt = fifo_cnt + int'(pend_wr) - int'(pend_rd);

            if (!did_rst && m_writing && m_written >= 310) begin
                #2;
                sys_rst = 1'b1;
                #1;
                check(fifo_wr_en == 1'b0, "async_rst_wr_en", int'(fifo_wr_en), 0);
                check(int'(fifo_wdata) == DATA_INIT, "async_rst_wdata", int'(fifo_wdata), DATA_INIT);
                check(burst_done == 1'b0, "async_rst_burst_done", int'(burst_done), 0);
                check(burst_cnt == 16'h0000, "async_rst_burst_cnt", int'(burst_cnt), 0);
                m_writing = 1'b0;
                m_settle  = 0;
                m_written = 0;
                m_bursts  = 0;
                wr_q.delete();
                done_q.delete();
                pend_wr = 1'b0;
                pend_rd = 1'b0;
                did_rst = 1'b1;
                @(negedge sys_clk);
                sys_rst = 1'b0;
            end

            if (!did_wp && m_written >= 16 && m_settle == 5) begin
                busy_left = 1;
                did_wp    = 1'b1;
            end
            if (!did_wrp && m_writing && m_written >= 40) begin
                busy_left = 1;
                did_wrp   = 1'b1;
            end
            if (busy_left == 0 && m_written >= 48 && $urandom_range(0, 149) == 0) begin
                busy_left = int'($urandom_range(1, 3));
            end
            wr_rst_busy = (busy_left > 0);
            if (busy_left > 0) busy_left--;

            almost_empty = (fifo_cnt <= 1);
            almost_full  = (fifo_cnt >= 15);
            full         = (fifo_cnt >= 16);
            drain        = !m_writing && m_settle == 0 && !almost_empty;

            if (did_rst && !did_t6 && m_writing && m_written >= 6) begin
                almost_empty = 1'b1;
                almost_full  = 1'b1;
                did_t6       = 1'b1;
            end

            if (fifo_wr_en) check(!full, "write_while_full", int'(full), 0);

            model_step();

            rd      = drain && fifo_cnt > 0 && $urandom_range(0, 3) != 0;
            pend_wr = fifo_wr_en;
            pend_rd = rd;
            @(negedge sys_clk);
        end

        check(wr_q.size() == 0, "pending_writes_at_end", wr_q.size(), 0);
        check(done_q.size() == 0, "pending_burst_done_at_end", done_q.size(), 0);
        check(int'(burst_cnt) == m_bursts % 65536, "final_burst_cnt", int'(burst_cnt), m_bursts % 65536);
        check(wr_seen >= 300, "writes_observed", wr_seen, 300);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
